// File: rtl/logic_pkg.sv
// Shared definitions for the bitwise logic datapath: op encoding and a
// width-parametrised population count.
package logic_pkg;

    localparam int unsigned OP_W      = 3;
    localparam int unsigned POP_MAX_W = 1024;

    typedef enum logic [OP_W-1:0] {
        OP_AND   = 3'b000,
        OP_OR    = 3'b001,
        OP_XOR   = 3'b010,
        OP_XNOR  = 3'b011,
        OP_NAND  = 3'b100,
        OP_NOR   = 3'b101,
        OP_NOTA  = 3'b110,
        OP_PASSA = 3'b111
    } op_e;

    // Counts ones in the low 'width' bits; callers zero-extend into v.
    function automatic int unsigned popcount_w(input logic [POP_MAX_W-1:0] v,
                                               input int unsigned width);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < POP_MAX_W; i++) begin
            if (i < width) begin
                n = n + 32'(v[i]);
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/logic_stream_unit_bitwise_op.sv
// Combinational WIDTH-wide bitwise op mux feeding the first pipeline stage.
module bitwise_op
    import logic_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_e              op,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        unique case (op)
            OP_AND:   y = a & b;
            OP_OR:    y = a | b;
            OP_XOR:   y = a ^ b;
            OP_XNOR:  y = ~(a ^ b);
            OP_NAND:  y = ~(a & b);
            OP_NOR:   y = ~(a | b);
            OP_NOTA:  y = ~a;
            OP_PASSA: y = a;
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/logic_stream_unit.sv
// Two-stage valid/ready bitwise logic unit with popcount and a saturating
// accumulator of ones over completed output transfers.
module logic_stream_unit
    import logic_pkg::*;
#(
    parameter  int unsigned WIDTH  = 8,
    parameter  int unsigned ACC_W  = 16,
    localparam int unsigned ONES_W = $clog2(WIDTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
    input  logic [OP_W-1:0]   in_op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_y,
    output logic [ONES_W-1:0] out_ones,
    input  logic              acc_clr,
    output logic [ACC_W-1:0]  out_acc
);

    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    logic              s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0]  s1_y_q, s1_y_d;
    logic              s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0]  s2_y_q, s2_y_d;
    logic [ONES_W-1:0] s2_ones_q, s2_ones_d;
    logic [ACC_W-1:0]  acc_q, acc_d;

    logic              ready_1, ready_2;
    logic              out_xfer;
    logic [WIDTH-1:0]  op_y;
    logic [ACC_W:0]    acc_sum;

    bitwise_op #(.WIDTH(WIDTH)) u_bitwise_op (
        .a  (in_a),
        .b  (in_b),
        .op (op_e'(in_op)),
        .y  (op_y)
    );

    always_comb begin
        ready_2    = !s2_valid_q || out_ready;
        ready_1    = !s1_valid_q || ready_2;
        out_xfer   = s2_valid_q && out_ready;

        s1_valid_d = s1_valid_q;
        s1_y_d     = s1_y_q;
        s2_valid_d = s2_valid_q;
        s2_y_d     = s2_y_q;
        s2_ones_d  = s2_ones_q;

        if (ready_1) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_y_d = op_y;
            end
        end

        if (ready_2) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_y_d    = s1_y_q;
                s2_ones_d = ONES_W'(popcount_w(POP_MAX_W'(s1_y_q), WIDTH));
            end
        end

        // One extra bit so the carry out of the add flags saturation.
        acc_sum = {1'b0, acc_q} + (ACC_W + 1)'(s2_ones_q);
        acc_d   = acc_q;
        if (acc_clr) begin
            acc_d = out_xfer ? ACC_W'(s2_ones_q) : '0;
        end else if (out_xfer) begin
            acc_d = acc_sum[ACC_W] ? ACC_MAX : acc_sum[ACC_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_y_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_y_q     <= '0;
            s2_ones_q  <= '0;
            acc_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_y_q     <= s1_y_d;
            s2_valid_q <= s2_valid_d;
            s2_y_q     <= s2_y_d;
            s2_ones_q  <= s2_ones_d;
            acc_q      <= acc_d;
        end
    end

    assign in_ready  = ready_1;
    assign out_valid = s2_valid_q;
    assign out_y     = s2_y_q;
    assign out_ones  = s2_ones_q;
    assign out_acc   = acc_q;

endmodule

// File: tb/tb_logic_stream_unit.sv
// Directed and random-stream checks of logic_stream_unit at WIDTH=8, ACC_W=4.
module tb_logic_stream_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_a = '0;
    logic [7:0] in_b = '0;
    logic [2:0] in_op = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_y;
    logic [3:0] out_ones;
    logic       acc_clr = 1'b0;
    logic [3:0] out_acc;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] ops_y    [8] = '{8'h82, 8'hEE, 8'h6C, 8'h93, 8'h7D, 8'h11, 8'h35, 8'hCA};
    logic [3:0] ops_ones [8] = '{4'd2, 4'd6, 4'd4, 4'd4, 4'd6, 4'd2, 4'd4, 4'd4};

    logic_stream_unit #(.WIDTH(8), .ACC_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_ones  (out_ones),
        .acc_clr   (acc_clr),
        .out_acc   (out_acc)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] model_y(input logic [2:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return ~(a ^ b);
            3'd4:    return ~(a & b);
            3'd5:    return ~(a | b);
            3'd6:    return ~a;
            default: return a;
        endcase
    endfunction

    function automatic logic [3:0] model_ones(input logic [7:0] v);
        logic [3:0] n;
        n = 0;
        for (int i = 0; i < 8; i++) n = n + {3'b0, v[i]};
        return n;
    endfunction

    task automatic test_reset();
        #12;
        n_checks++;
        if ({out_valid, out_y, out_ones, out_acc, in_ready} !== {1'b0, 8'h00, 4'd0, 4'd0, 1'b1})
            $display("FAIL reset_hold: got v=%b y=%h ones=%0d acc=%0d rdy=%b expected 0/00/0/0/1",
                     out_valid, out_y, out_ones, out_acc, in_ready);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({out_valid, out_y, out_ones, out_acc, in_ready} !== {1'b0, 8'h00, 4'd0, 4'd0, 1'b1})
            $display("FAIL reset_idle: got v=%b y=%h ones=%0d acc=%0d rdy=%b expected 0/00/0/0/1",
                     out_valid, out_y, out_ones, out_acc, in_ready);
        else n_pass++;
    endtask

    task automatic test_all_ops();
        out_ready = 1'b1;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            n_checks++;
            if (k >= 2 && k < 10) begin
                if (out_valid !== 1'b1 || out_y !== ops_y[k-2] || out_ones !== ops_ones[k-2])
                    $display("FAIL op%0d: got v=%b y=%h ones=%0d expected v=1 y=%h ones=%0d",
                             k - 2, out_valid, out_y, out_ones, ops_y[k-2], ops_ones[k-2]);
                else n_pass++;
            end else begin
                if (out_valid !== 1'b0)
                    $display("FAIL ops_idle%0d: got out_valid=%b expected 0", k, out_valid);
                else n_pass++;
            end
            if (k < 8) begin
                in_valid = 1'b1;
                in_a = 8'hCA;
                in_b = 8'hA6;
                in_op = k[2:0];
            end else begin
                in_valid = 1'b0;
            end
        end
        // 2+6+4+4 already exceeds 15
        n_checks++;
        if (out_acc !== 4'd15) $display("FAIL ops_acc_sat: got %0d expected 15", out_acc);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_y [3] = '{8'h30, 8'h81, 8'hF0};
        logic [3:0] exp_o [3] = '{4'd2, 4'd2, 4'd4};
        logic acc_t;
        int got;
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = 3'd0; in_a = 8'hF0; in_b = 8'h3C;
        @(negedge clk);
        in_op = 3'd1; in_a = 8'h01; in_b = 8'h80;
        @(negedge clk);
        in_op = 3'd2; in_a = 8'hFF; in_b = 8'h0F;
        #1;
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_y !== 8'h30)
            $display("FAIL bp_full: got rdy=%b v=%b y=%h expected 0/1/30", in_ready, out_valid, out_y);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_y !== 8'h30 || out_ones !== 4'd2)
                $display("FAIL bp_stall%0d: got rdy=%b v=%b y=%h ones=%0d expected 0/1/30/2",
                         i, in_ready, out_valid, out_y, out_ones);
            else n_pass++;
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL bp_passthru: got in_ready=%b expected 1", in_ready);
        else n_pass++;
        got = 0;
        for (int c = 0; c < 8 && got < 3; c++) begin
            if (out_valid) begin
                n_checks++;
                if (out_y !== exp_y[got] || out_ones !== exp_o[got])
                    $display("FAIL bp_drain%0d: got y=%h ones=%0d expected y=%h ones=%0d",
                             got, out_y, out_ones, exp_y[got], exp_o[got]);
                else n_pass++;
                got++;
            end
            acc_t = in_valid && in_ready;
            @(negedge clk);
            if (acc_t) in_valid = 1'b0;
            #1;
        end
        n_checks++;
        if (got !== 3 || out_valid !== 1'b0)
            $display("FAIL bp_count: got %0d results, out_valid=%b expected 3 results, 0", got, out_valid);
        else n_pass++;
    endtask

    task automatic test_acc_saturation();
        @(negedge clk);
        acc_clr = 1'b1;
        @(negedge clk);
        acc_clr = 1'b0;
        n_checks++;
        if (out_acc !== 4'd0) $display("FAIL acc_clr_idle: got %0d expected 0", out_acc);
        else n_pass++;
        for (int k = 0; k < 6; k++) begin
            if (k == 2) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_y !== 8'hFF || out_ones !== 4'd8)
                    $display("FAIL acc_full_ones: got v=%b y=%h ones=%0d expected 1/FF/8",
                             out_valid, out_y, out_ones);
                else n_pass++;
            end
            if (k >= 3) begin
                n_checks++;
                if (out_acc !== ((k == 3) ? 4'd8 : 4'd15))
                    $display("FAIL acc_sat%0d: got %0d expected %0d", k - 3, out_acc,
                             (k == 3) ? 8 : 15);
                else n_pass++;
            end
            if (k < 3) begin
                in_valid = 1'b1; in_op = 3'd3; in_a = 8'hFF; in_b = 8'hFF;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b1; in_op = 3'd0; in_a = 8'h07; in_b = 8'hFF;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        acc_clr = 1'b1;
        @(negedge clk);
        acc_clr = 1'b0;
        n_checks++;
        if (out_acc !== 4'd3) $display("FAIL acc_clr_xfer: got %0d expected 3", out_acc);
        else n_pass++;
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = 3'd7; in_a = 8'h5A; in_b = 8'h00;
        @(negedge clk);
        in_op = 3'd6; in_a = 8'h5A;
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_acc !== 4'd3)
            $display("FAIL rst_pre: got v=%b rdy=%b acc=%0d expected 1/0/3", out_valid, in_ready, out_acc);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, out_y, out_ones, out_acc, in_ready} !== {1'b0, 8'h00, 4'd0, 4'd0, 1'b1})
            $display("FAIL rst_async: got v=%b y=%h ones=%0d acc=%0d rdy=%b expected 0/00/0/0/1",
                     out_valid, out_y, out_ones, out_acc, in_ready);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1; in_op = 3'd1; in_a = 8'h0F; in_b = 8'h30;
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL rst_lat1: got out_valid=%b expected 0", out_valid);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || out_y !== 8'h3F || out_ones !== 4'd6)
            $display("FAIL rst_lat2: got v=%b y=%h ones=%0d expected 1/3F/6", out_valid, out_y, out_ones);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [11:0] q[$];
        logic [11:0] e;
        int acc_model, xfers, cyc;
        logic xf;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        acc_clr = 1'b1;
        @(negedge clk);
        acc_clr = 1'b0;
        acc_model = 0;
        xfers = 0;
        cyc = 0;
        while (xfers < 10000 && cyc < 60000) begin
            n_checks++;
            if (out_acc !== 4'(acc_model))
                $display("FAIL rnd_acc cyc %0d: got %0d expected %0d", cyc, out_acc, acc_model);
            else n_pass++;
            in_valid  = ($urandom_range(3) != 0);
            in_a      = 8'($urandom);
            in_b      = 8'($urandom);
            in_op     = 3'($urandom_range(7));
            out_ready = ($urandom_range(3) != 0);
            acc_clr   = ($urandom_range(63) == 0);
            #1;
            xf = out_valid && out_ready;
            e = '0;
            if (xf) begin
                n_checks++;
                if (q.size() == 0) begin
                    $display("FAIL rnd_extra cyc %0d: got y=%h with empty scoreboard expected none", cyc, out_y);
                end else begin
                    e = q.pop_front();
                    if (out_y !== e[11:4] || out_ones !== e[3:0])
                        $display("FAIL rnd_data xfer %0d: got y=%h ones=%0d expected y=%h ones=%0d",
                                 xfers, out_y, out_ones, e[11:4], e[3:0]);
                    else n_pass++;
                end
                xfers++;
            end
            if (in_valid && in_ready) begin
                q.push_back({model_y(in_op, in_a, in_b), model_ones(model_y(in_op, in_a, in_b))});
            end
            if (acc_clr) acc_model = xf ? int'(e[3:0]) : 0;
            else if (xf) acc_model = (acc_model + int'(e[3:0]) > 15) ? 15 : acc_model + int'(e[3:0]);
            @(negedge clk);
            cyc++;
        end
        acc_clr = 1'b0;
        in_valid = 1'b0;
        n_checks++;
        if (xfers < 10000) $display("FAIL rnd_timeout: got %0d transfers expected 10000", xfers);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_all_ops();
        test_backpressure();
        test_acc_saturation();
        test_reset_midstream();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
